qos_dispatcher: RTL and testbench

//  Read-side counterpart of the per-ID QoS tracker. Accepts tagged requests (ID + QoS) into an
//  ID-indexed pending table. Issues one pending entry at a time: highest QoS first, round-robin

---
 rtl/qos_pkg.sv | 17 +
 rtl/qos_rr_pick.sv | 58 +++++
 rtl/qos_dispatcher.sv | 81 ++++++++
 tb/tb_qos_dispatcher.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/qos_pkg.sv
// Shared sizes and types for the QoS dispatcher and its round-robin picker.
package qos_pkg;

    localparam int ID_W   = 4;
    localparam int QOS_W  = 3;
    localparam int NUM_ID = 1 << ID_W;

    typedef logic [ID_W-1:0]  id_t;
    typedef logic [QOS_W-1:0] qos_t;
    typedef logic [ID_W:0]    cnt_t;

    typedef struct packed {
        id_t  id;
        qos_t qos;
    } req_t;

endpackage

// File: rtl/qos_rr_pick.sv
// Combinational winner select: highest QoS among pending entries, ties broken
// round-robin starting at rr_ptr.
module qos_rr_pick
    import qos_pkg::*;
(
    input  logic [NUM_ID-1:0]            pend,
    input  logic [NUM_ID-1:0][QOS_W-1:0] qos,
    input  logic [ID_W-1:0]              rr_ptr,
    output logic                         any,
    output logic [ID_W-1:0]              winner,
    output logic [QOS_W-1:0]             max_qos
);

    localparam int LVLS = (1 << QOS_W) - 1;

    logic [LVLS-1:0]   therm_or;
    logic [NUM_ID-1:0] elig;
    id_t               idx;
    logic              found;

    // Bit k of the OR'd thermometer is set when some pending qos exceeds k,
    // so the number of set bits is the maximum pending qos.
    always_comb begin
        therm_or = '0;
        for (int i = 0; i < NUM_ID; i++) begin
            for (int k = 0; k < LVLS; k++) begin
                if (pend[i] && (qos[i] > qos_t'(k))) therm_or[k] = 1'b1;
            end
        end
        max_qos = '0;
        for (int k = 0; k < LVLS; k++) begin
            max_qos = max_qos + qos_t'(therm_or[k]);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_ID; i++) begin
            elig[i] = pend[i] && (qos[i] == max_qos);
        end
    end

    // idx wraps naturally at ID_W bits, giving the modulo-NUM_ID search.
    always_comb begin
        winner = rr_ptr;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < NUM_ID; i++) begin
            idx = rr_ptr + id_t'(i);
            if (!found && elig[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign any = |pend;

endmodule

// File: rtl/qos_dispatcher.sv
// ID-indexed pending table issuing one entry at a time, highest QoS first with
// round-robin among equals, through a registered valid/ready output stage.
module qos_dispatcher
    import qos_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [ID_W-1:0]  in_id,
    input  logic [QOS_W-1:0] in_qos,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [ID_W-1:0]  out_id,
    output logic [QOS_W-1:0] out_qos,
    output logic [QOS_W-1:0] max_qos,
    output logic [ID_W:0]    count,
    output logic             err_dup
);

    logic [NUM_ID-1:0]            pend;
    logic [NUM_ID-1:0][QOS_W-1:0] qos_tbl;
    id_t                          rr_ptr;

    req_t req;
    logic in_fire, dup, any, load;
    id_t  winner;

    assign req     = '{id: in_id, qos: in_qos};
    assign in_rdy  = ~rst;
    assign in_fire = in_vld & in_rdy;
    // An ID sitting in the output register is still in flight.
    assign dup     = pend[req.id] | (out_vld & (out_id == req.id));
    assign load    = any & (~out_vld | out_rdy);

    qos_rr_pick u_pick (
        .pend    (pend),
        .qos     (qos_tbl),
        .rr_ptr  (rr_ptr),
        .any     (any),
        .winner  (winner),
        .max_qos (max_qos)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pend    <= '0;
            qos_tbl <= '0;
            rr_ptr  <= '0;
            out_vld <= 1'b0;
            out_id  <= '0;
            out_qos <= '0;
            err_dup <= 1'b0;
        end else begin
            err_dup <= in_fire & dup;
            if (in_fire && !dup) begin
                pend[req.id]    <= 1'b1;
                qos_tbl[req.id] <= req.qos;
            end
            // The loaded ID is pending, so it can never equal an accepted one.
            if (load) begin
                out_vld      <= 1'b1;
                out_id       <= winner;
                out_qos      <= qos_tbl[winner];
                pend[winner] <= 1'b0;
                rr_ptr       <= winner + id_t'(1);
            end else if (out_vld && out_rdy) begin
                out_vld <= 1'b0;
            end
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < NUM_ID; i++) begin
            count = count + cnt_t'(pend[i]);
        end
        count = count + cnt_t'(out_vld);
    end

endmodule

// File: tb/tb_qos_dispatcher.sv
// Bench for qos_dispatcher: cycle model of the issue rules plus directed scenarios.
module tb_qos_dispatcher;
    import qos_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_vld = 1'b0;
    logic             out_rdy = 1'b0;
    logic [ID_W-1:0]  in_id = '0;
    logic [QOS_W-1:0] in_qos = '0;
    logic             in_rdy, out_vld, err_dup;
    logic [ID_W-1:0]  out_id;
    logic [QOS_W-1:0] out_qos, max_qos;
    logic [ID_W:0]    count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit started = 0;
    int iss[$];
    int hs_cyc[$];

    qos_dispatcher dut (
        .clk(clk), .rst(rst),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_id(in_id), .in_qos(in_qos),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_id(out_id), .out_qos(out_qos),
        .max_qos(max_qos), .count(count), .err_dup(err_dup)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: pending set, per-ID qos, tie pointer and output slot.
    bit m_pend[NUM_ID];
    int m_qos[NUM_ID];
    int m_rr, m_oid, m_oqos, best, w, idx;
    bit m_ov, m_err, dupv, ld;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ID; i++) begin
                m_pend[i] = 0;
                m_qos[i]  = 0;
            end
            m_rr = 0; m_ov = 0; m_oid = 0; m_oqos = 0; m_err = 0;
            started = 1;
        end else begin
            best = -1;
            w = -1;
            for (int k = 0; k < NUM_ID; k++) begin
                idx = (m_rr + k) % NUM_ID;
                if (m_pend[idx] && m_qos[idx] > best) begin
                    best = m_qos[idx];
                    w = idx;
                end
            end
            dupv  = m_pend[in_id] || (m_ov && m_oid == int'(in_id));
            ld    = (w >= 0) && (!m_ov || out_rdy);
            m_err = in_vld && dupv;
            if (in_vld && !dupv) begin
                m_pend[in_id] = 1;
                m_qos[in_id]  = int'(in_qos);
            end
            if (ld) begin
                m_ov = 1; m_oid = w; m_oqos = m_qos[w];
                m_pend[w] = 0;
                m_rr = (w + 1) % NUM_ID;
            end else if (m_ov && out_rdy) begin
                m_ov = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            int ec, em;
            ec = m_ov ? 1 : 0;
            em = 0;
            for (int i = 0; i < NUM_ID; i++) begin
                if (m_pend[i]) begin
                    ec++;
                    if (m_qos[i] > em) em = m_qos[i];
                end
            end
            chk("in_rdy", in_rdy, !rst);
            chk("out_vld", out_vld, m_ov);
            chk("count", count, ec);
            chk("max_qos", max_qos, em);
            chk("err_dup", err_dup, m_err);
            if (m_ov) begin
                chk("out_id", out_id, m_oid);
                chk("out_qos", out_qos, m_oqos);
            end
            if (out_vld === 1'b1 && out_rdy && !rst) begin
                iss.push_back(int'(out_id));
                hs_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int id, input int q);
        in_vld = 1'b1;
        in_id  = ID_W'(id);
        in_qos = QOS_W'(q);
        tick();
        in_vld = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_rdy = 1'b1;
        while (count != 0 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: count %0d still nonzero after %0d cycles", count, n);
        end
    endtask

    int exp2[4] = '{0, 1, 7, 3};
    int exp3[6] = '{0, 4, 8, 0, 4, 8};

    initial begin
        // 1. reset and idle
        tick(); tick();
        chk("rst_count", count, 0);
        chk("rst_vld", out_vld, 0);
        chk("rst_rdy", in_rdy, 0);
        rst = 1'b0;
        tick();
        chk("idle_count", count, 0);
        chk("idle_max", max_qos, 0);
        chk("idle_rdy", in_rdy, 1);

        // 2. priority order; id0 parks in the output so rr_ptr moves to 1
        out_rdy = 1'b0;
        req(0, 0); req(3, 2); req(7, 5); req(1, 5);
        chk("t2_hold_id", out_id, 0);
        chk("t2_count", count, 4);
        chk("t2_max", max_qos, 5);
        tick(); tick();
        chk("t2_stable_id", out_id, 0);
        iss.delete();
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
        chk("t2_first", out_id, 1);
        tick(); tick();
        chk("t2_hold1_vld", out_vld, 1);
        chk("t2_hold1_id", out_id, 1);
        chk("t2_hold1_qos", out_qos, 5);
        drain();
        chk("t2_n", iss.size(), 4);
        for (int i = 0; i < 4 && i < iss.size(); i++) chk("t2_order", iss[i], exp2[i]);

        // mid-traffic reset
        out_rdy = 1'b0;
        req(2, 6); req(6, 1);
        rst = 1'b1;
        tick();
        chk("mrst_count", count, 0);
        chk("mrst_vld", out_vld, 0);
        chk("mrst_max", max_qos, 0);
        rst = 1'b0;
        tick();

        // 3. round-robin among equal qos with re-requests
        out_rdy = 1'b0;
        req(0, 3); req(4, 3); req(8, 3);
        iss.delete();
        out_rdy = 1'b1;
        begin
            int n;
            n = 0;
            for (int c = 0; c < 10; c++) begin
                if (iss.size() > n) begin
                    n = iss.size();
                    in_vld = 1'b1;
                    in_id  = ID_W'(iss[n-1]);
                    in_qos = 3'd3;
                end else begin
                    in_vld = 1'b0;
                end
                tick();
            end
            in_vld = 1'b0;
        end
        drain();
        chk("t3_n_ge6", iss.size() >= 6, 1);
        for (int i = 0; i < 6 && i < iss.size(); i++) chk("t3_order", iss[i], exp3[i]);

        // 4. duplicates against pending and against the output slot
        out_rdy = 1'b0;
        req(9, 1); req(5, 4); req(5, 6);
        chk("t4_dup_pend", err_dup, 1);
        chk("t4_max_kept", max_qos, 4);
        tick();
        chk("t4_dup_pulse", err_dup, 0);
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
        chk("t4_out5", out_id, 5);
        chk("t4_out5_qos", out_qos, 4);
        req(5, 2);
        chk("t4_dup_out", err_dup, 1);
        out_rdy = 1'b1;
        tick();
        req(5, 2);
        chk("t4_reuse_nodup", err_dup, 0);
        chk("t4_reuse_count", count, 1);
        chk("t4_reuse_max", max_qos, 2);
        tick();
        chk("t4_reissue_id", out_id, 5);
        chk("t4_reissue_qos", out_qos, 2);
        drain();

        // 5. latency and streaming throughput
        out_rdy = 1'b1;
        req(2, 1);
        chk("t5_lat0_vld", out_vld, 0);
        chk("t5_lat0_cnt", count, 1);
        tick();
        chk("t5_lat1_vld", out_vld, 1);
        chk("t5_lat1_id", out_id, 2);
        drain();
        iss.delete();
        hs_cyc.delete();
        for (int i = 0; i < NUM_ID; i++) req(i, i % 8);
        drain();
        chk("t5_n", iss.size(), 16);
        for (int i = 0; i < 16 && i < iss.size(); i++) chk("t5_order", iss[i], i);
        if (hs_cyc.size() == 16) chk("t5_b2b", hs_cyc[15] - hs_cyc[0], 15);

        // 6. full table
        out_rdy = 1'b0;
        for (int i = 0; i < NUM_ID; i++) req(i, (i * 3) % 8);
        chk("t6_full_count", count, 16);
        chk("t6_full_max", max_qos, 7);
        req(9, 4);
        chk("t6_full_dup", err_dup, 1);
        chk("t6_full_count2", count, 16);
        drain();
        chk("t6_end_max", max_qos, 0);
        chk("t6_end_count", count, 0);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
